// File: rtl/bus_initiator_if.sv
// Upstream command/result channel and peripheral valid/ready bus used by
// bus_initiator. The master modport is the initiator's view; the slave
// modport is the view of whatever surrounds it (command source + responder).
`timescale 1ns/1ps
interface bus_initiator_if;
  // Upstream command channel
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic [3:0]  cmd_sel_i;
  logic        cmd_we_i;
  // Upstream result channel
  logic        res_valid_o;
  logic        res_ready_i;
  logic [31:0] res_data_o;
  logic        res_err_o;
  // Peripheral bus
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic [31:0] data_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        rsp_valid_i;
  logic        rsp_ready_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_data_i, cmd_sel_i, cmd_we_i,
    output cmd_ready_o,
    output res_valid_o, res_data_o, res_err_o,
    input  res_ready_i,
    output addr_o, data_o, sel_o, we_o, req_valid_o, rsp_ready_o,
    input  data_i, req_ready_i, rsp_valid_i
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_data_i, cmd_sel_i, cmd_we_i,
    input  cmd_ready_o,
    input  res_valid_o, res_data_o, res_err_o,
    output res_ready_i,
    input  addr_o, data_o, sel_o, we_o, req_valid_o, rsp_ready_o,
    output data_i, req_ready_i, rsp_valid_i
  );
endinterface

// File: rtl/bus_initiator.sv
// Single-outstanding bus master: takes one command from upstream, issues it
// on the peripheral valid/ready bus, waits for the response and returns the
// read data upstream.
// Optional transaction timeout: define BUS_INITIATOR_TIMEOUT_EN to compile in
// a 16-bit REQ+RSP cycle counter that aborts with res_err_o=1 after
// TIMEOUT_CYCLES cycles. Without it the initiator waits indefinitely.
`timescale 1ns/1ps
module bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_initiator_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_initiator: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_q, req_valid_q, res_valid_q, rsp_ready_q;
  logic [31:0] addr_q, wdata_q, res_data_q;
  logic [3:0]  sel_q;
  logic        we_q, res_err_q;

  logic accept;      // command handshake this cycle
  logic capture;     // response completes the transaction this cycle
  logic abort;       // timeout expires with no completing response
  logic timeout_hit;

`ifdef BUS_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q;

  assign timeout_hit = (tmo_cnt_q == TMO_LAST);

  // Cycle counter: cleared on entry to REQ, counts every REQ/RSP cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= 16'd0;
    end else if (accept) begin
      tmo_cnt_q <= 16'd0;
    end else if (state_q == REQ || state_q == RSP) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state decode; a completing response takes priority over expiry
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i && cmd_ready_q) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.req_ready_i && bus.rsp_valid_i) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = DONE;
        end else if (bus.req_ready_i) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_valid_i) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered handshake outputs, all decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      req_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == IDLE);
      req_valid_q <= (state_d == REQ);
      res_valid_q <= (state_d == DONE);
      rsp_ready_q <= 1'b1;
    end
  end

  // Bus request fields: loaded on command accept, held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.cmd_addr_i;
      wdata_q <= bus.cmd_data_i;
      sel_q   <= bus.cmd_sel_i;
      we_q    <= bus.cmd_we_i;
    end
  end

  // Result capture; stray responses outside REQ/RSP never reach here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q <= 32'h0;
      res_err_q  <= 1'b0;
    end else if (capture) begin
      res_data_q <= we_q ? 32'h0 : bus.data_i;
      res_err_q  <= 1'b0;
    end else if (abort) begin
      res_data_q <= 32'h0;
      res_err_q  <= 1'b1;
    end
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.req_valid_o = req_valid_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.rsp_ready_o = rsp_ready_q;
  assign bus.addr_o      = addr_q;
  assign bus.data_o      = wdata_q;
  assign bus.sel_o       = sel_q;
  assign bus.we_o        = we_q;
  assign bus.res_data_o  = res_data_q;
  assign bus.res_err_o   = res_err_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: a scripted command source and
// responder, with expected results queued at command time and compared
// when the initiator presents them upstream.
`timescale 1ns/1ps
module tb_bus_initiator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_initiator_if bif();

  bus_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.master)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cmd_ready();
    int n = 0;
    while (!bif.cmd_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", bif.cmd_ready_o, 1);
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, input logic we);
    bif.cmd_valid_i = 1'b1;
    bif.cmd_addr_i  = addr;
    bif.cmd_data_i  = wdata;
    bif.cmd_sel_i   = sel;
    bif.cmd_we_i    = we;
    @(negedge clk);
    bif.cmd_valid_i = 1'b0;
    bif.cmd_addr_i  = $urandom;
    bif.cmd_data_i  = $urandom;
  endtask

  // Pop the scoreboard and compare against the presented result
  task automatic check_result(output res_t exp);
    chk("res_valid", bif.res_valid_o, 1);
    chk("sb_nonempty", sb_q.size() > 0, 1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    chk("res_data", bif.res_data_o, exp.data);
    chk("res_err", bif.res_err_o, exp.err);
  endtask

  task automatic res_handshake();
    bif.res_ready_i = 1'b1;
    @(negedge clk);
    bif.res_ready_i = 1'b0;
    chk("res_drop", bif.res_valid_o, 0);
    chk("cmd_ready_back", bif.cmd_ready_o, 1);
  endtask

  // One full transaction.
  // req_dly: cycles req_ready_i is held low (stray rsp_valid_i driven then)
  // rsp_dly: cycles from request handshake to response (0 = same cycle)
  // res_dly: cycles of upstream backpressure on the result
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input logic we,
                        input logic [31:0] rdata,
                        input int req_dly, input int rsp_dly, input int res_dly);
    res_t exp;
    wait_cmd_ready();
    sb_q.push_back('{data: (we ? 32'h0 : rdata), err: 1'b0});
    send_cmd(addr, wdata, sel, we);
    chk("req_valid_up", bif.req_valid_o, 1);
    chk("cmd_ready_busy", bif.cmd_ready_o, 0);
    chk("bus_addr", bif.addr_o, addr);
    chk("bus_data", bif.data_o, wdata);
    chk("bus_sel_we", {bif.sel_o, bif.we_o}, {sel, we});
    for (int i = 0; i < req_dly; i++) begin
      bif.rsp_valid_i = 1'b1;
      bif.data_i      = 32'hBAD0_0000 | i;
      @(negedge clk);
      chk("req_hold_valid", bif.req_valid_o, 1);
      chk("req_hold_addr", bif.addr_o, addr);
      chk("req_hold_data", bif.data_o, wdata);
      chk("req_hold_sel_we", {bif.sel_o, bif.we_o}, {sel, we});
    end
    bif.rsp_valid_i = 1'b0;
    bif.req_ready_i = 1'b1;
    if (rsp_dly == 0) begin
      bif.rsp_valid_i = 1'b1;
      bif.data_i      = rdata;
    end
    @(negedge clk);
    bif.req_ready_i = 1'b0;
    bif.rsp_valid_i = 1'b0;
    bif.data_i      = $urandom;
    chk("req_drop", bif.req_valid_o, 0);
    if (rsp_dly > 0) begin
      chk("no_early_res", bif.res_valid_o, 0);
      for (int i = 1; i < rsp_dly; i++) @(negedge clk);
      bif.rsp_valid_i = 1'b1;
      bif.data_i      = rdata;
      @(negedge clk);
      bif.rsp_valid_i = 1'b0;
      bif.data_i      = $urandom;
    end
    check_result(exp);
    for (int i = 0; i < res_dly; i++) begin
      @(negedge clk);
      chk("bp_valid", bif.res_valid_o, 1);
      chk("bp_data", bif.res_data_o, exp.data);
      chk("bp_cmd_ready", bif.cmd_ready_o, 0);
    end
    res_handshake();
  endtask

  // A response with no outstanding request must not disturb anything
  task automatic stray_rsp(input logic [31:0] junk);
    bif.rsp_valid_i = 1'b1;
    bif.data_i      = junk;
    chk("stray_rsp_ready", bif.rsp_ready_o, 1);
    @(negedge clk);
    bif.rsp_valid_i = 1'b0;
    chk("stray_no_res", bif.res_valid_o, 0);
    chk("stray_cmd_ready", bif.cmd_ready_o, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {bif.cmd_ready_o, bif.req_valid_o, bif.res_valid_o,
                         bif.rsp_ready_o, bif.res_err_o, bif.we_o}, 0);
    chk({tag, "_addr_data"}, {bif.addr_o, bif.data_o}, 0);
    chk({tag, "_res_sel"}, {bif.res_data_o, bif.sel_o}, 0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bif.cmd_valid_i = 1'b0;
    bif.cmd_addr_i  = '0;
    bif.cmd_data_i  = '0;
    bif.cmd_sel_i   = '0;
    bif.cmd_we_i    = 1'b0;
    bif.res_ready_i = 1'b0;
    bif.data_i      = '0;
    bif.req_ready_i = 1'b0;
    bif.rsp_valid_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", bif.cmd_ready_o, 1);
    chk("post_reset_rsp_ready", bif.rsp_ready_o, 1);

    // Read, registered 1-cycle responder
    do_txn(32'h1000_0008, 32'h0, 4'hF, 1'b0, 32'h0000_00FF, 0, 1, 0);
    // Write with sel, request stalled 3 cycles (stray rsp during stall ignored)
    do_txn(32'h1000_0000, 32'h0000_0003, 4'b0001, 1'b1, 32'hFFFF_FFFF, 3, 2, 0);
    // Same-cycle responder
    do_txn(32'h1000_0010, 32'h0, 4'hF, 1'b0, 32'hA5A5_A5A5, 0, 0, 0);
    // Upstream backpressure
    do_txn(32'h1000_0014, 32'h0, 4'hF, 1'b0, 32'h1357_9BDF, 0, 1, 5);
    // Stray response in IDLE, then a normal read
    stray_rsp(32'hDEAD_BEEF);
    do_txn(32'h2000_0004, 32'h0, 4'hF, 1'b0, 32'h0BAD_F00D, 1, 3, 1);

`ifdef BUS_INITIATOR_TIMEOUT_EN
    // Timeout: request accepted, response never comes
    begin
      res_t exp;
      int   n = 0;
      wait_cmd_ready();
      sb_q.push_back('{data: 32'h0, err: 1'b1});
      send_cmd(32'h1000_0020, 32'h0, 4'hF, 1'b0);
      bif.req_ready_i = 1'b1;
      while (!bif.res_valid_o && n < 40) begin
        @(negedge clk);
        n++;
      end
      bif.req_ready_i = 1'b0;
      chk("tmo_latency", n, 8);
      check_result(exp);
      res_handshake();
      stray_rsp(32'h5555_AAAA);
      do_txn(32'h1000_0024, 32'h0, 4'hF, 1'b0, 32'h600D_DA7A, 0, 1, 0);
    end
`endif

    // Async reset while waiting in RSP
    wait_cmd_ready();
    send_cmd(32'h3000_0000, 32'h0, 4'hF, 1'b0);
    bif.req_ready_i = 1'b1;
    @(negedge clk);
    bif.req_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_cmd_ready", bif.cmd_ready_o, 1);
    chk("rerst_req_valid", bif.req_valid_o, 0);
    do_txn(32'h3000_0004, 32'h0, 4'hF, 1'b0, 32'hCAFE_0001, 0, 1, 0);

    // A few randomised transactions
    for (int k = 0; k < 4; k++) begin
      do_txn($urandom, $urandom, 4'($urandom), 1'($urandom), $urandom,
             $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
